line_buffer_l4: RTL and testbench



---
 rtl/line_buffer_l4_pkg.sv | 23 ++
 rtl/line_buffer_l4_if.sv | 28 ++
 rtl/line_buffer_l4_row_ram.sv | 27 ++
 rtl/line_buffer_l4.sv | 100 ++++++++++
 tb/tb_line_buffer_l4.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/line_buffer_l4_pkg.sv
// line_buffer_l4_pkg: shared pixel/width types and fill-state encoding for the four-row line buffer
package line_buffer_l4_pkg;

    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int MAX_WIDTH_DEF   = 2048;

    // 11-bit row width / column type, shared with the disparity window block
    typedef logic [10:0] width_t;

    // Fill progress after sof: number of complete rows already stored, saturating at RUN
    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        RUN   = 2'd3
    } lb_state_e;

    // A width of 0 would never wrap; treat it as a one-pixel row
    function automatic width_t clamp_width(input width_t w);
        return (w == '0) ? width_t'(1) : w;
    endfunction

endpackage

// File: rtl/line_buffer_l4_if.sv
// line_buffer_l4_if: pixel stream in, four vertically aligned taps out
interface line_buffer_l4_if
    import line_buffer_l4_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF
);
    logic                   clken;
    logic                   sof;
    width_t                 width;
    logic [PIXEL_WIDTH-1:0] pixel_in;
    logic [PIXEL_WIDTH-1:0] linebuffer0;
    logic [PIXEL_WIDTH-1:0] linebuffer1;
    logic [PIXEL_WIDTH-1:0] linebuffer2;
    logic [PIXEL_WIDTH-1:0] linebuffer3;
    width_t                 col;
    logic                   en;

    modport master (
        output clken, sof, width, pixel_in,
        input  linebuffer0, linebuffer1, linebuffer2, linebuffer3, col, en
    );

    modport slave (
        input  clken, sof, width, pixel_in,
        output linebuffer0, linebuffer1, linebuffer2, linebuffer3, col, en
    );

endinterface

// File: rtl/line_buffer_l4_row_ram.sv
// lb_row_ram: one stored image row; read-first single-port RAM, write gated by clken
module lb_row_ram
    import line_buffer_l4_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int MAX_WIDTH   = MAX_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   clken,
    input  width_t                 addr,
    input  logic [PIXEL_WIDTH-1:0] wr_data,
    output logic [PIXEL_WIDTH-1:0] rd_data
);

    logic [PIXEL_WIDTH-1:0] mem [MAX_WIDTH];

    // Read sees the old word; the new word lands on the edge, so a same-address
    // read/write (the normal case here) resolves read-first. The caller's tap
    // register captures rd_data on the same clken edge.
    assign rd_data = mem[addr];

    // Contents are never reset: stale rows survive reset and sof
    always_ff @(posedge clock) begin
        if (clken) mem[addr] <= wr_data;
    end

endmodule

// File: rtl/line_buffer_l4.sv
// line_buffer_l4: four-row line buffer presenting rows r..r-3 of one column; optional LB_BORDER_ZERO_EN zeroes taps of rows not yet filled
module line_buffer_l4
    import line_buffer_l4_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int MAX_WIDTH   = MAX_WIDTH_DEF
) (
    input  logic              clock,
    input  logic              rst,
    line_buffer_l4_if.slave   bus
);

`ifdef LB_BORDER_ZERO_EN
    localparam bit BORDER_ZERO = 1'b1;
`else
    localparam bit BORDER_ZERO = 1'b0;
`endif

    width_t                 wr_col_q, wr_col_d;
    width_t                 width_q, width_d;
    width_t                 col_q, col_d;
    lb_state_e              state_q, state_d;
    logic                   en_q, en_d;
    logic [PIXEL_WIDTH-1:0] lb0_q, lb0_d, lb1_q, lb1_d, lb2_q, lb2_d, lb3_q, lb3_d;
    logic [PIXEL_WIDTH-1:0] rd1, rd2, rd3;
    width_t                 cur_col, row_len;
    lb_state_e              cur_state;
    logic                   wrap;

    // Pointer and fill-state next values; sof restarts the frame for the pixel on this cycle
    always_comb begin
        cur_col   = bus.sof ? '0 : wr_col_q;
        cur_state = bus.sof ? FILL0 : state_q;
        row_len   = (cur_col == '0) ? clamp_width(bus.width) : width_q;
        wrap      = cur_col == row_len - 11'd1;
        wr_col_d  = !bus.clken ? wr_col_q : wrap ? '0 : cur_col + 11'd1;
        width_d   = bus.clken ? row_len : width_q;
        state_d   = !bus.clken ? state_q
                  : (wrap && cur_state != RUN) ? lb_state_e'(cur_state + 2'd1) : cur_state;
        en_d      = bus.clken ? (cur_state == RUN) : en_q;
        col_d     = bus.clken ? cur_col : col_q;
    end

    // Tap next values; rows that do not exist yet read as zero in the border-zero build
    always_comb begin
        lb0_d = bus.clken ? bus.pixel_in : lb0_q;
        lb1_d = !bus.clken ? lb1_q : (BORDER_ZERO && cur_state < FILL1) ? '0 : rd1;
        lb2_d = !bus.clken ? lb2_q : (BORDER_ZERO && cur_state < FILL2) ? '0 : rd2;
        lb3_d = !bus.clken ? lb3_q : (BORDER_ZERO && cur_state < RUN)   ? '0 : rd3;
    end

    // Fill-state register
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) state_q <= FILL0;
        else      state_q <= state_d;
    end

    // Pointer, width and output registers
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_col_q <= '0;
            width_q  <= 11'd1;
            col_q    <= '0;
            en_q     <= 1'b0;
            lb0_q    <= '0;
            lb1_q    <= '0;
            lb2_q    <= '0;
            lb3_q    <= '0;
        end else begin
            wr_col_q <= wr_col_d;
            width_q  <= width_d;
            col_q    <= col_d;
            en_q     <= en_d;
            lb0_q    <= lb0_d;
            lb1_q    <= lb1_d;
            lb2_q    <= lb2_d;
            lb3_q    <= lb3_d;
        end
    end

    lb_row_ram #(.PIXEL_WIDTH(PIXEL_WIDTH), .MAX_WIDTH(MAX_WIDTH)) u_ram1 (
        .clock(clock), .clken(bus.clken), .addr(cur_col), .wr_data(bus.pixel_in), .rd_data(rd1)
    );

    lb_row_ram #(.PIXEL_WIDTH(PIXEL_WIDTH), .MAX_WIDTH(MAX_WIDTH)) u_ram2 (
        .clock(clock), .clken(bus.clken), .addr(cur_col), .wr_data(rd1), .rd_data(rd2)
    );

    lb_row_ram #(.PIXEL_WIDTH(PIXEL_WIDTH), .MAX_WIDTH(MAX_WIDTH)) u_ram3 (
        .clock(clock), .clken(bus.clken), .addr(cur_col), .wr_data(rd2), .rd_data(rd3)
    );

    assign bus.linebuffer0 = lb0_q;
    assign bus.linebuffer1 = lb1_q;
    assign bus.linebuffer2 = lb2_q;
    assign bus.linebuffer3 = lb3_q;
    assign bus.col         = col_q;
    assign bus.en          = en_q;

endmodule

// File: tb/tb_line_buffer_l4.sv
// tb_line_buffer_l4: randomized and directed checks of line_buffer_l4 against a per-column history model
module tb_line_buffer_l4;
    import line_buffer_l4_pkg::*;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    line_buffer_l4_if bus ();
    line_buffer_l4 dut (.clock(clock), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [7:0] taps [4];
    assign taps[0] = bus.linebuffer0;
    assign taps[1] = bus.linebuffer1;
    assign taps[2] = bus.linebuffer2;
    assign taps[3] = bus.linebuffer3;

    // Model: for every column, the last three pixels ever written there (newest first).
    // Tap k shows the k-th most recent earlier pixel of the same column.
    logic [7:0] h  [2048][3];
    int         hc [2048];
    int         m_col, m_row, m_wlen;
    logic [7:0] e_lb [4];
    bit         e_kn [4];
    int         e_col;
    bit         e_en;

    task automatic step(input bit ce, input bit s, input int w, input logic [7:0] p);
        @(negedge clock);
        bus.clken = ce; bus.sof = s; bus.width = width_t'(w); bus.pixel_in = p;
        @(posedge clock);
        #1;
        if (ce) begin
            if (s) begin m_col = 0; m_row = 0; end
            if (m_col == 0) m_wlen = (w == 0) ? 1 : w;
            e_lb[0] = p; e_kn[0] = 1'b1; e_col = m_col; e_en = (m_row >= 3);
            for (int k = 1; k < 4; k++) begin
                e_kn[k] = hc[m_col] >= k;
                if (e_kn[k]) e_lb[k] = h[m_col][k-1];
`ifdef LB_BORDER_ZERO_EN
                if (m_row < k) begin e_kn[k] = 1'b1; e_lb[k] = 8'd0; end
`endif
            end
            h[m_col][2] = h[m_col][1];
            h[m_col][1] = h[m_col][0];
            h[m_col][0] = p;
            if (hc[m_col] < 3) hc[m_col]++;
            m_col++;
            if (m_col == m_wlen) begin
                m_col = 0;
                if (m_row < 3) m_row++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        rst = 1'b0; bus.clken = 1'b0; bus.sof = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (taps[k] !== 8'd0) begin failures++; $display("FAIL reset_tap%0d got=%0h exp=0", k, taps[k]); end
        end
        checks++;
        if (bus.col !== 11'd0) begin failures++; $display("FAIL reset_col got=%0d exp=0", bus.col); end
        checks++;
        if (bus.en !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", bus.en); end
        m_col = 0; m_row = 0; m_wlen = 1; e_col = 0; e_en = 1'b0;
        for (int k = 0; k < 4; k++) begin e_lb[k] = 8'd0; e_kn[k] = 1'b1; end
        @(negedge clock);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        bit seen = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            step(1'b1, i == 0, 4, 8'(i));
            for (int k = 0; k < 4; k++) if (e_kn[k]) begin
                checks++;
                if (taps[k] !== e_lb[k]) begin failures++; $display("FAIL fill_tap%0d got=%0d exp=%0d", k, taps[k], e_lb[k]); end
            end
            checks++;
            if (bus.col !== 11'(e_col)) begin failures++; $display("FAIL fill_col got=%0d exp=%0d", bus.col, e_col); end
            checks++;
            if (bus.en !== e_en) begin failures++; $display("FAIL fill_en got=%0b exp=%0b", bus.en, e_en); end
            if (bus.en === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if ({taps[0], taps[1], taps[2], taps[3], bus.col} !== {8'd12, 8'd8, 8'd4, 8'd0, 11'd0}) begin
                    failures++;
                    $display("FAIL fill_first_en got=%0d,%0d,%0d,%0d col=%0d exp=12,8,4,0 col=0", taps[0], taps[1], taps[2], taps[3], bus.col);
                end
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL fill_en_seen got=0 exp=1"); end
    endtask

    task automatic test_clken_gaps();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, i == 1, 4, 8'(i));
            for (int g = 0; g < 2; g++) begin
                for (int k = 0; k < 4; k++) if (e_kn[k]) begin
                    checks++;
                    if (taps[k] !== e_lb[k]) begin failures++; $display("FAIL gaps_tap%0d got=%0d exp=%0d", k, taps[k], e_lb[k]); end
                end
                checks++;
                if (bus.col !== 11'(e_col) || bus.en !== e_en) begin
                    failures++;
                    $display("FAIL gaps_col_en got=%0d/%0b exp=%0d/%0b", bus.col, bus.en, e_col, e_en);
                end
                if (g == 0) step(1'b0, 1'b1, 2, 8'($urandom));
            end
        end
    endtask

    task automatic test_width1();
        step(1'b1, 1'b1, 1, 8'd10);
        step(1'b1, 1'b0, 1, 8'd11);
        step(1'b1, 1'b0, 1, 8'd12);
        checks++;
        if (bus.en !== 1'b0) begin failures++; $display("FAIL w1_en_early got=%0b exp=0", bus.en); end
        step(1'b1, 1'b0, 1, 8'd13);
        checks++;
        if ({bus.en, taps[0], taps[1], taps[2], taps[3], bus.col} !== {1'b1, 8'd13, 8'd12, 8'd11, 8'd10, 11'd0}) begin
            failures++;
            $display("FAIL w1_taps got=%0b %0d,%0d,%0d,%0d col=%0d exp=1 13,12,11,10 col=0", bus.en, taps[0], taps[1], taps[2], taps[3], bus.col);
        end
    endtask

    task automatic test_width_change();
        int exp_col;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i == 0, (i < 2) ? 4 : 6, 8'(100 + i));
            exp_col = (i < 4) ? i : (i - 4) % 6;
            checks++;
            if (bus.col !== 11'(exp_col) || bus.col > 11'd5) begin
                failures++; $display("FAIL wchg_col idx=%0d got=%0d exp=%0d", i, bus.col, exp_col);
            end
            for (int k = 0; k < 4; k++) if (e_kn[k]) begin
                checks++;
                if (taps[k] !== e_lb[k]) begin failures++; $display("FAIL wchg_tap%0d got=%0d exp=%0d", k, taps[k], e_lb[k]); end
            end
        end
    endtask

    task automatic test_resof();
        for (int i = 0; i < 10; i++) step(1'b1, i == 0, 3, 8'($urandom));
        checks++;
        if (bus.en !== 1'b1) begin failures++; $display("FAIL resof_en_before got=%0b exp=1", bus.en); end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i == 0, 3, 8'($urandom));
            if (i == 0) begin
                checks++;
                if (bus.en !== 1'b0 || bus.col !== 11'd0) begin
                    failures++; $display("FAIL resof_clear got=%0b/%0d exp=0/0", bus.en, bus.col);
                end
            end
            for (int k = 0; k < 4; k++) if (e_kn[k]) begin
                checks++;
                if (taps[k] !== e_lb[k]) begin failures++; $display("FAIL resof_tap%0d got=%0d exp=%0d", k, taps[k], e_lb[k]); end
            end
            checks++;
            if (bus.en !== (i == 9)) begin failures++; $display("FAIL resof_en idx=%0d got=%0b exp=%0b", i, bus.en, i == 9); end
        end
    endtask

    task automatic test_rst_mid();
        int n = 0;
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, 5, 8'($urandom));
        test_reset();
        while (n < 40 && bus.en !== 1'b1) begin
            step(1'b1, n == 0, 5, 8'($urandom));
            n++;
        end
        checks++;
        if (n != 16) begin failures++; $display("FAIL rst_mid_en_pixel got=%0d exp=16", n); end
    endtask

    task automatic test_random();
        int w = 4;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 40) == 0) w = $urandom_range(0, 7);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 70) == 0, w, 8'($urandom));
            for (int k = 0; k < 4; k++) if (e_kn[k]) begin
                checks++;
                if (taps[k] !== e_lb[k]) begin failures++; $display("FAIL rand_tap%0d i=%0d got=%0d exp=%0d", k, i, taps[k], e_lb[k]); end
            end
            checks++;
            if (bus.col !== 11'(e_col)) begin failures++; $display("FAIL rand_col i=%0d got=%0d exp=%0d", i, bus.col, e_col); end
            checks++;
            if (bus.en !== e_en) begin failures++; $display("FAIL rand_en i=%0d got=%0b exp=%0b", i, bus.en, e_en); end
        end
    endtask

    initial begin
        bus.clken = 1'b0; bus.sof = 1'b0; bus.width = 11'd4; bus.pixel_in = 8'd0;
        for (int c = 0; c < 2048; c++) hc[c] = 0;
        repeat (2) @(posedge clock);
        test_reset();
        test_fill();
        test_clken_gaps();
        test_width1();
        test_width_change();
        test_resof();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
